// File: rtl/posit_field_unpack.sv
// Two-stage unpack of decoded posit fields into a signed binary scale and a
// hidden-bit-prefixed mantissa, with valid/ready flow control on both sides.
module posit_field_unpack #(
    parameter int width = 32,
    parameter int es    = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_sign,
    input  logic signed [width-2:0]                   in_regime,
    input  logic        [width-2:0]                   in_exponent,
    input  logic        [width-2:0]                   in_fraction,
    input  logic                                      in_zero,
    input  logic                                      in_nar,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_sign,
    output logic signed [$clog2(width)+es:0]          out_scale,
    output logic        [width-1:0]                   out_mant,
    output logic                                      out_zero,
    output logic                                      out_nar
);

    localparam int SW = $clog2(width) + es + 1;

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [width-2:0] s1_regime;
    logic        [es-1:0]    s1_exponent;
    logic        [width-2:0] s1_fraction;
    logic                    s1_zero;
    logic                    s1_nar;

    logic                    s2_valid;
    logic                    s1_adv;
    logic                    s2_adv;

    logic signed [SW-1:0]    regime_ext;
    logic signed [SW-1:0]    regime_shifted;
    logic signed [SW-1:0]    exponent_ext;
    logic signed [SW-1:0]    scale_calc;
    logic                    special;

    // Only the low es bits of the exponent carry information.
    logic                    unused_exponent_bits;
    assign unused_exponent_bits = ^in_exponent[width-2:es];

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        regime_ext     = SW'(s1_regime);
        regime_shifted = regime_ext <<< es;
        exponent_ext   = SW'(s1_exponent);
        scale_calc     = regime_shifted + exponent_ext;
        special        = s1_zero || s1_nar;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_regime   <= '0;
            s1_exponent <= '0;
            s1_fraction <= '0;
            s1_zero     <= 1'b0;
            s1_nar      <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign     <= in_sign;
                s1_regime   <= in_regime;
                s1_exponent <= in_exponent[es-1:0];
                s1_fraction <= in_fraction;
                s1_zero     <= in_zero;
                s1_nar      <= in_nar;
            end
        end
    end

    // NaR dominates zero when both flags arrive together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_sign  <= 1'b0;
            out_scale <= '0;
            out_mant  <= '0;
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= special ? 1'b0 : s1_sign;
                out_scale <= special ? '0 : scale_calc;
                out_mant  <= special ? '0 : {1'b1, s1_fraction};
                out_zero  <= s1_zero && !s1_nar;
                out_nar   <= s1_nar;
            end
        end
    end

endmodule

// File: tb/tb_posit_field_unpack.sv
// Scoreboard bench for posit_field_unpack (width=16, es=1): directed cases,
// streaming, random backpressure and reset-while-full.
module tb_posit_field_unpack;

    localparam int W  = 16;
    localparam int ES = 1;
    localparam int SW = $clog2(W) + ES + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_sign = 1'b0;
    logic signed [W-2:0]  in_regime = '0;
    logic        [W-2:0]  in_exponent = '0;
    logic        [W-2:0]  in_fraction = '0;
    logic                 in_zero = 1'b0;
    logic                 in_nar = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 out_sign;
    logic signed [SW-1:0] out_scale;
    logic        [W-1:0]  out_mant;
    logic                 out_zero;
    logic                 out_nar;

    posit_field_unpack #(.width(W), .es(ES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_regime(in_regime), .in_exponent(in_exponent),
        .in_fraction(in_fraction), .in_zero(in_zero), .in_nar(in_nar),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_scale(out_scale), .out_mant(out_mant),
        .out_zero(out_zero), .out_nar(out_nar)
    );

    always #5 clk = ~clk;

    typedef struct {
        int scale;
        int mant;
        bit sign;
        bit zero;
        bit nar;
        int acc;
        bit lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b0;
    bit   rnd_ready = 1'b0;
    bit   hold_ready = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: scale = k * 2^es + e, mantissa = 2^(W-1) + fraction.
    function automatic exp_t model(input bit s, input int k, input int e, input int f,
                                   input bit z, input bit n);
        exp_t r;
        r.nar  = n;
        r.zero = z && !n;
        if (z || n) begin
            r.scale = 0;
            r.mant  = 0;
            r.sign  = 0;
        end else begin
            r.scale = k * (2 ** ES) + e;
            r.mant  = (2 ** (W - 1)) + f;
            r.sign  = s;
        end
        r.acc = 0;
        r.lat = 0;
        return r;
    endfunction

    exp_t push_item;
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            push_item     = model(in_sign, int'(in_regime), int'(in_exponent),
                                  int'(in_fraction), in_zero, in_nar);
            push_item.acc = cyc;
            push_item.lat = lat_mode;
            q.push_back(push_item);
        end
        cyc++;
    end

    exp_t    got;
    bit      prev_stall = 1'b0;
    int      prev_vec;
    int      cur_vec;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur_vec = int'({out_valid, out_sign, out_zero, out_nar, out_scale, out_mant});
            if (prev_stall)
                check("stall_hold", cur_vec, prev_vec);
            check("in_ready_occupancy", int'(in_ready), int'(!(q.size() == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got scale %0d mant %0d, expected no output",
                             int'(out_scale), int'(out_mant));
                end else begin
                    got = q.pop_front();
                    check("scale", int'(out_scale), got.scale);
                    check("mant", int'(out_mant), got.mant);
                    check("sign", int'(out_sign), int'(got.sign));
                    check("zero", int'(out_zero), int'(got.zero));
                    check("nar", int'(out_nar), int'(got.nar));
                    if (got.lat)
                        check("latency", cyc, got.acc + 2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = cur_vec;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_ready ? 1'($urandom % 2) : hold_ready;
        end
    end

    task automatic send(input bit s, input int k, input int e, input int f,
                        input bit z, input bit n);
        int budget;
        bit acc;
        budget      = 0;
        acc         = 1'b0;
        in_valid    = 1'b1;
        in_sign     = s;
        in_regime   = (W-1)'(k);
        in_exponent = (W-1)'(e);
        in_fraction = (W-1)'(f);
        in_zero     = z;
        in_nar      = n;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!acc && budget < 200);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", budget);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 100) begin
            idle(1);
            budget++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_sign", int'(out_sign), 0);
        check("reset_out_scale", int'(out_scale), 0);
        check("reset_out_mant", int'(out_mant), 0);
        check("reset_out_zero", int'(out_zero), 0);
        check("reset_out_nar", int'(out_nar), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", int'(in_ready), 1);
        @(posedge clk);
        #1;

        lat_mode = 1'b1;
        send(0, 3, 1, 'h4000, 0, 0);
        idle(3);
        send(1, -2, 1, 'h0001, 0, 0);
        idle(3);
        send(1, 5, 1, 'h0123, 1, 0);
        send(0, -4, 0, 'h0007, 1, 1);
        send(1, -14, 0, 'h7fff, 0, 0);
        send(0, 14, 1, 'h0000, 0, 0);
        idle(4);

        for (int i = 0; i < 20; i++)
            send(1'($urandom % 2), int'($urandom_range(0, 28)) - 14,
                 int'($urandom_range(0, 1)), int'($urandom % (2 ** (W - 1))), 0, 0);
        drain();
        lat_mode = 1'b0;

        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom % 3 == 0)
                idle(int'($urandom_range(1, 2)));
            send(1'($urandom % 2), int'($urandom_range(0, 28)) - 14,
                 int'($urandom_range(0, 1)), int'($urandom % (2 ** (W - 1))),
                 1'($urandom % 8 == 0), 1'($urandom % 8 == 0));
        end
        rnd_ready  = 1'b0;
        hold_ready = 1'b1;
        drain();

        hold_ready = 1'b0;
        idle(1);
        send(0, 2, 1, 'h0100, 0, 0);
        send(1, -3, 0, 'h0200, 0, 0);
        idle(1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        @(negedge clk);
        check("reset_flush_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        hold_ready = 1'b1;
        idle(10);
        check("post_reset_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
